// File: rtl/vme_bus_arbiter_if.sv
// VME arbitration bus bundle: backplane request/grant/busy/clear lines plus grant status.
// Latency: none (wiring only).
// Backpressure: none; BBSY from the owning master is what holds off the next grant.
interface vme_bus_arbiter_if #(
    parameter int LEVELS = 4,
    parameter int LW     = $clog2(LEVELS)
);
    logic              mode_rr;
    logic [LEVELS-1:0] vme_br;
    logic              vme_bbsy;
    logic              vme_sysclk;
    logic [LEVELS-1:0] vme_bgout;
    logic              vme_bclr;
    logic              grant_valid;
    logic [LW-1:0]     grant_level;
    logic              bto_pulse;

    // Arbiter side
    modport master (
        input  mode_rr, vme_br, vme_bbsy,
        output vme_sysclk, vme_bgout, vme_bclr, grant_valid, grant_level, bto_pulse
    );

    // Backplane / system side
    modport slave (
        output mode_rr, vme_br, vme_bbsy,
        input  vme_sysclk, vme_bgout, vme_bclr, grant_valid, grant_level, bto_pulse
    );
endinterface

// File: rtl/vme_bus_arbiter.sv
// VME system-controller arbiter: PRI / round-robin grant, BCLR pre-emption, bus-grant timeout.
// Latency: 3 clocks from a BR falling edge (bus idle) to BGOUT low.
// Backpressure: a new grant waits for BBSY high; a timer withdraws an unclaimed grant.
module vme_bus_arbiter #(
    parameter int LEVELS    = 4,
    parameter int BTO_LIMIT = 255,
    parameter int BTO_W     = 8
) (
    input  logic              clock,
    input  logic              reset,
    vme_bus_arbiter_if.master bus
);
    localparam int LW = $clog2(LEVELS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    state_t            state;
    logic [LEVELS-1:0] br_meta;
    logic [LEVELS-1:0] br_s;
    logic              bbsy_meta;
    logic              bbsy_s;
    logic [BTO_W-1:0]  timer;
    logic [LW-1:0]     rr_last;
    logic              rr_mode_q;

    logic [LEVELS-1:0] bgout_q;
    logic              bclr_q;
    logic              gv_q;
    logic [LW-1:0]     gl_q;
    logic              bto_q;

    logic              any_req;
    logic [LW-1:0]     winner;
    logic [LEVELS-1:0] grant_mask;
    logic              preempt;

    assign bus.vme_sysclk  = clock;
    assign bus.vme_bgout   = bgout_q;
    assign bus.vme_bclr    = bclr_q;
    assign bus.grant_valid = gv_q;
    assign bus.grant_level = gl_q;
    assign bus.bto_pulse   = bto_q;

    // Two-flop synchronisers; idle (high) is the reset value for the active-low lines.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            br_meta   <= '1;
            br_s      <= '1;
            bbsy_meta <= 1'b1;
            bbsy_s    <= 1'b1;
        end else begin
            br_meta   <= bus.vme_br;
            br_s      <= br_meta;
            bbsy_meta <= bus.vme_bbsy;
            bbsy_s    <= bbsy_meta;
        end
    end

    assign any_req = ~&br_s;

    // Winner search. RRS scans offsets from the largest down so the nearest
    // level after rr_last overwrites any farther candidate.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        if (bus.mode_rr) begin
            for (int k = LEVELS; k >= 1; k--) begin
                idx = (int'(rr_last) + k) % LEVELS;
                if (!br_s[idx]) winner = idx[LW-1:0];
            end
        end else begin
            for (int i = 0; i < LEVELS; i++) begin
                if (!br_s[i]) winner = i[LW-1:0];
            end
        end
    end

    always_comb begin
        grant_mask         = '1;
        grant_mask[winner] = 1'b0;
    end

    // Pre-emption uses the mode captured when the current owner was granted.
    always_comb begin
        preempt = 1'b0;
        for (int i = 0; i < LEVELS; i++) begin
            if (!br_s[i]) begin
                if (rr_mode_q) begin
                    if (i[LW-1:0] != gl_q) preempt = 1'b1;
                end else if (i > int'(gl_q)) begin
                    preempt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            bgout_q   <= '1;
            bclr_q    <= 1'b1;
            gv_q      <= 1'b0;
            gl_q      <= '0;
            bto_q     <= 1'b0;
            timer     <= '0;
            rr_last   <= LW'(LEVELS - 1);
            rr_mode_q <= 1'b0;
        end else begin
            bto_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    bgout_q <= '1;
                    bclr_q  <= 1'b1;
                    if (any_req && bbsy_s) begin
                        gl_q      <= winner;
                        bgout_q   <= grant_mask;
                        gv_q      <= 1'b1;
                        timer     <= '0;
                        rr_mode_q <= bus.mode_rr;
                        if (bus.mode_rr) rr_last <= winner;
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    timer <= timer + 1'b1;
                    // A claimed bus beats a timeout landing on the same clock.
                    if (!bbsy_s) begin
                        bgout_q <= '1;
                        state   <= ST_BUSY;
                    end else if (timer == BTO_W'(BTO_LIMIT)) begin
                        bgout_q <= '1;
                        bto_q   <= 1'b1;
                        gv_q    <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    bgout_q <= '1;
                    if (bbsy_s) begin
                        gv_q  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (preempt) begin
                        bclr_q <= 1'b0;
                        state  <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (bbsy_s) begin
                        bclr_q <= 1'b1;
                        gv_q   <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    bgout_q <= '1;
                    bclr_q  <= 1'b1;
                    gv_q    <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vme_bus_arbiter.sv
// Bench for vme_bus_arbiter: directed backplane scenarios checked against a cycle model.
module tb_vme_bus_arbiter;
    localparam int LEVELS    = 4;
    localparam int BTO_LIMIT = 10;
    localparam int BTO_W     = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    vme_bus_arbiter_if #(.LEVELS(LEVELS)) bus ();

    vme_bus_arbiter #(
        .LEVELS   (LEVELS),
        .BTO_LIMIT(BTO_LIMIT),
        .BTO_W    (BTO_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [LEVELS-1:0] m_br_d1, m_br_s;
    logic              m_bbsy_d1, m_bbsy_s;
    int                m_owner, m_age, m_rr_last;
    bit                m_offered, m_held, m_clearing, m_rr;
    logic [LEVELS-1:0] e_bgout;
    logic              e_bclr, e_bto;

    function automatic int pick(input logic [LEVELS-1:0] br, input bit rr, input int last);
        if (rr) begin
            for (int off = 1; off <= LEVELS; off++)
                if (!br[(last + off) % LEVELS]) return (last + off) % LEVELS;
        end else begin
            for (int i = LEVELS - 1; i >= 0; i--)
                if (!br[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit contender(input logic [LEVELS-1:0] br, input int owner, input bit rr);
        for (int i = 0; i < LEVELS; i++)
            if (!br[i] && (rr ? (i != owner) : (i > owner))) return 1'b1;
        return 1'b0;
    endfunction

    initial forever begin
        @(posedge clock or negedge reset);
        if (!reset) begin
            m_br_d1 = '1; m_br_s = '1; m_bbsy_d1 = 1'b1; m_bbsy_s = 1'b1;
            m_owner = -1; m_age = 0; m_rr_last = LEVELS - 1;
            m_offered = 0; m_held = 0; m_clearing = 0; m_rr = 0;
            e_bgout = '1; e_bclr = 1'b1; e_bto = 1'b0;
        end else begin
            e_bto = 1'b0;
            if (m_offered) begin
                if (!m_bbsy_s) begin
                    m_offered = 0; m_held = 1; e_bgout = '1;
                end else if (m_age == BTO_LIMIT) begin
                    m_offered = 0; m_owner = -1; e_bgout = '1; e_bto = 1'b1;
                end
                m_age++;
            end else if (m_clearing) begin
                if (m_bbsy_s) begin
                    m_clearing = 0; m_held = 0; m_owner = -1; e_bclr = 1'b1;
                end
            end else if (m_held) begin
                if (m_bbsy_s) begin
                    m_held = 0; m_owner = -1;
                end else if (contender(m_br_s, m_owner, m_rr)) begin
                    m_clearing = 1; e_bclr = 1'b0;
                end
            end else if (m_br_s != '1 && m_bbsy_s) begin
                m_rr    = bus.mode_rr;
                m_owner = pick(m_br_s, m_rr, m_rr_last);
                if (m_rr) m_rr_last = m_owner;
                m_offered = 1; m_age = 0;
                e_bgout = '1; e_bgout[m_owner] = 1'b0;
            end
            m_br_s   = m_br_d1;   m_br_d1   = bus.vme_br;
            m_bbsy_s = m_bbsy_d1; m_bbsy_d1 = bus.vme_bbsy;
        end
    end

    // Every-cycle comparison of the DUT against the model.
    initial forever begin
        @(negedge clock);
        if (reset) begin
            chk("bgout", int'(bus.vme_bgout), int'(e_bgout));
            chk("bclr", int'(bus.vme_bclr), int'(e_bclr));
            chk("bto_pulse", int'(bus.bto_pulse), int'(e_bto));
            chk("grant_valid", int'(bus.grant_valid), (m_owner >= 0) ? 1 : 0);
            if (m_owner >= 0) chk("grant_level", int'(bus.grant_level), m_owner);
            chk("bgout_onehot", ($countones(~bus.vme_bgout) <= 1) ? 1 : 0, 1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_bg(input logic [LEVELS-1:0] val, input int bound, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (bus.vme_bgout !== val && n < bound);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (bus.grant_valid !== 1'b0 && n < 40);
        chk(name, int'(bus.grant_valid), 0);
    endtask

    int n, n_low, bclr_seen;
    logic [LEVELS-1:0] exp_bg;

    initial begin
        bus.vme_br   = '1;
        bus.vme_bbsy = 1'b1;
        bus.mode_rr  = 1'b0;
        #1 reset = 1'b0;
        #2;
        chk("rst_bgout", int'(bus.vme_bgout), 15);
        chk("rst_bclr", int'(bus.vme_bclr), 1);
        chk("rst_gv", int'(bus.grant_valid), 0);
        chk("rst_gl", int'(bus.grant_level), 0);
        chk("rst_bto", int'(bus.bto_pulse), 0);
        @(negedge clock);
        #2 reset = 1'b1;

        // 1: PRI single request, latency, then owner takes BBSY
        @(negedge clock);
        bus.vme_br = 4'b1110;
        wait_bg(4'b1110, 10, n);
        chk("t1_grant_latency", n, 3);
        bus.vme_bbsy = 1'b0;
        wait_bg(4'b1111, 10, n);
        chk("t1_release_latency", n, 3);
        chk("t1_gl", int'(bus.grant_level), 0);
        chk("t1_gv", int'(bus.grant_valid), 1);
        bus.vme_br = '1;
        cyc(2);
        bus.vme_bbsy = 1'b1;
        wait_idle("t1_idle");

        // 2: PRI pre-emption of level 0 by level 2
        cyc(1);
        bus.vme_br = 4'b1110;
        wait_bg(4'b1110, 10, n);
        chk("t2_grant0", n, 3);
        bus.vme_bbsy = 1'b0;
        bus.vme_br   = 4'b1111;
        wait_bg(4'b1111, 10, n);
        cyc(1);
        bus.vme_br = 4'b1011;
        n = 0;
        do begin @(negedge clock); n++; end while (bus.vme_bclr !== 1'b0 && n < 10);
        chk("t2_bclr_latency", n, 3);
        bus.vme_bbsy = 1'b1;
        wait_bg(4'b1011, 12, n);
        chk("t2_regrant", n, 4);
        chk("t2_bclr_high", int'(bus.vme_bclr), 1);
        chk("t2_gl", int'(bus.grant_level), 2);
        bus.vme_bbsy = 1'b0;
        bus.vme_br   = '1;
        cyc(4);
        bus.vme_bbsy = 1'b1;
        wait_idle("t2_idle");

        // 5: BBSY release coincident with a higher request: no BCLR
        cyc(1);
        bus.vme_br = 4'b1110;
        wait_bg(4'b1110, 10, n);
        bus.vme_bbsy = 1'b0;
        bus.vme_br   = 4'b1111;
        wait_bg(4'b1111, 10, n);
        cyc(2);
        bus.vme_bbsy = 1'b1;
        bus.vme_br   = 4'b1011;
        n = 0;
        bclr_seen = 0;
        do begin
            @(negedge clock);
            n++;
            if (bus.vme_bclr === 1'b0) bclr_seen++;
        end while (bus.vme_bgout !== 4'b1011 && n < 10);
        chk("t5_grant_latency", n, 4);
        chk("t5_no_bclr", bclr_seen, 0);
        bus.vme_br = '1;
        wait_idle("t5_idle");

        // 4: grant timeout, single pulse, re-grant after one idle clock
        cyc(1);
        bus.vme_br = 4'b1101;
        wait_bg(4'b1101, 10, n);
        chk("t4_grant_latency", n, 3);
        n_low = 1;
        forever begin
            @(negedge clock);
            if (bus.vme_bgout !== 4'b1101 || n_low >= 30) break;
            n_low++;
        end
        chk("t4_low_clocks", n_low, BTO_LIMIT + 1);
        chk("t4_bto_pulse", int'(bus.bto_pulse), 1);
        chk("t4_gv_cleared", int'(bus.grant_valid), 0);
        wait_bg(4'b1101, 5, n);
        chk("t4_regrant_gap", n, 1);
        chk("t4_bto_once", int'(bus.bto_pulse), 0);
        bus.vme_br = '1;
        wait_idle("t4_idle");

        // 3: round-robin with all four requesting
        bus.mode_rr = 1'b1;
        cyc(1);
        bus.vme_br = '0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            do begin @(negedge clock); n++; end while (bus.vme_bgout === 4'b1111 && n < 20);
            exp_bg = '1;
            exp_bg[k % LEVELS] = 1'b0;
            chk("t3_rr_level", int'(bus.grant_level), k % LEVELS);
            chk("t3_rr_bgout", int'(bus.vme_bgout), int'(exp_bg));
            bus.vme_bbsy = 1'b0;
            cyc(5);
            if (k == 4) bus.vme_br = '1;
            bus.vme_bbsy = 1'b1;
            wait_idle("t3_idle");
        end
        bus.mode_rr = 1'b0;
        cyc(2);

        // 6: reset mid-grant
        bus.vme_br = 4'b0111;
        wait_bg(4'b0111, 10, n);
        chk("t6_grant3", n, 3);
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_bgout", int'(bus.vme_bgout), 15);
        chk("t6_rst_bclr", int'(bus.vme_bclr), 1);
        chk("t6_rst_gv", int'(bus.grant_valid), 0);
        @(negedge clock);
        #2 reset = 1'b1;
        wait_bg(4'b0111, 10, n);
        chk("t6_after_reset", n, 3);
        chk("t6_gl", int'(bus.grant_level), 3);
        bus.vme_br = '1;
        wait_idle("t6_idle");

        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
